// File: rtl/kyber_fifo_defs_pkg.sv
// rtl/kyber_fifo_defs_pkg.sv - shared widths and feeder state encodings for the coefficient FIFO path
package kyber_fifo_defs;

    localparam int COEF_W     = 16;
    localparam int FEED_BUF_D = 4;
    localparam int FEED_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } feed_state_t;

endpackage

// File: rtl/feed_word_buf.sv
// rtl/feed_word_buf.sv - small register ring: push one word per cycle, pop the head pair at once
module feed_word_buf
    import kyber_fifo_defs::*;
#(
    parameter int DATA_W = COEF_W,
    parameter int BUF_D  = FEED_BUF_D,
    localparam int PTR_W = $clog2(BUF_D),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clkr,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop2,
    output logic [DATA_W-1:0] head_a,
    output logic [DATA_W-1:0] head_b,
    output logic [CNT_W-1:0]  cnt
);

    logic [DATA_W-1:0] mem [BUF_D];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    assign head_a = mem[head];
    assign head_b = mem[PTR_W'(head + PTR_W'(1))];

    always_ff @(posedge clkr or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < BUF_D; i++) mem[i] <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + PTR_W'(1);
            end
            if (pop2) head <= head + PTR_W'(2);
            unique case ({push, pop2})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(2);
                2'b11:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pair_feeder.sv
// rtl/fifo_pair_feeder.sv - pops coefficient words from the FIFO and feeds (a,b) pairs to fqmul
module fifo_pair_feeder
    import kyber_fifo_defs::*;
#(
    parameter int DATA_W = COEF_W,
    parameter int CNT_W  = FEED_CNT_W,
    parameter int BUF_D  = FEED_BUF_D
) (
    input  logic              clkr,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  npairs,
    input  logic              abort,
    input  logic              empty,
    output logic              fiford,
    input  logic [DATA_W-1:0] rddata,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              op_ready,
    output logic              busy,
    output logic              done
);

    localparam int BC_W = $clog2(BUF_D) + 1;
    localparam int CR_W = BC_W + 1;

    feed_state_t      state_q, state_d;
    logic [CNT_W-1:0] npairs_q;
    logic [CNT_W:0]   words_req;
    logic [CNT_W-1:0] pairs_done;
    logic             rd_pend;
    logic             done_q, done_d;
    logic [BC_W-1:0]  buf_cnt;
    logic [CR_W-1:0]  credit_use;
    logic             handshake;
    logic             last_pair;
    logic             words_all;

    // Words already held plus the one still in the RAM pipeline must fit the buffer.
    assign credit_use = CR_W'(buf_cnt) + CR_W'(rd_pend);
    assign words_all  = (words_req == {npairs_q, 1'b0});
    assign fiford     = (state_q == S_RUN) & !abort & !empty & !words_all
                      & (credit_use < CR_W'(BUF_D));

    assign op_valid   = (buf_cnt >= BC_W'(2));
    assign handshake  = op_valid & op_ready;
    assign last_pair  = handshake & (pairs_done == npairs_q - CNT_W'(1));
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

    feed_word_buf #(
        .DATA_W (DATA_W),
        .BUF_D  (BUF_D)
    ) u_buf (
        .clkr      (clkr),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (rd_pend),
        .push_data (rddata),
        .pop2      (handshake),
        .head_a    (op_a),
        .head_b    (op_b),
        .cnt       (buf_cnt)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (npairs != '0) state_d = S_RUN;
                    else              done_d  = 1'b1;
                end
            end
            S_RUN:   if (words_all) state_d = S_DRAIN;
            S_DRAIN: begin
                if (last_pair) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clkr or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            npairs_q   <= '0;
            words_req  <= '0;
            pairs_done <= '0;
            rd_pend    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (abort) begin
                words_req  <= '0;
                pairs_done <= '0;
                rd_pend    <= 1'b0;
            end else if (state_q == S_IDLE && start) begin
                npairs_q   <= npairs;
                words_req  <= '0;
                pairs_done <= '0;
                rd_pend    <= 1'b0;
            end else begin
                rd_pend    <= fiford;
                words_req  <= words_req + (CNT_W + 1)'(fiford);
                pairs_done <= pairs_done + CNT_W'(handshake);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pair_feeder.sv
// tb/tb_fifo_pair_feeder.sv - directed bench for fifo_pair_feeder with a behavioural FIFO/RAM model
module tb_fifo_pair_feeder;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clkr     = 1'b0;
    logic          rst_n    = 1'b1;
    logic          start    = 1'b0;
    logic [CW-1:0] npairs   = '0;
    logic          abort    = 1'b0;
    logic          empty;
    logic          fiford;
    logic [DW-1:0] rddata   = '0;
    logic          op_valid;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_ready = 1'b0;
    logic          busy;
    logic          done;

    fifo_pair_feeder #(.DATA_W(DW), .CNT_W(CW), .BUF_D(4)) dut (
        .clkr     (clkr),
        .rst_n    (rst_n),
        .start    (start),
        .npairs   (npairs),
        .abort    (abort),
        .empty    (empty),
        .fiford   (fiford),
        .rddata   (rddata),
        .op_valid (op_valid),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clkr = ~clkr;

    // FIFO + RAM model: data appears one cycle after an accepted pop.
    logic [DW-1:0] mem [0:127];
    int            wr_cnt = 0;
    int            rd_idx = 0;
    assign empty = (rd_idx >= wr_cnt);

    always @(posedge clkr) begin
        if (fiford && !empty) begin
            rddata <= mem[rd_idx];
            rd_idx <= rd_idx + 1;
        end
    end

    int            cyc = 0;
    int            pop_n = 0;
    int            acc_n = 0;
    int            done_n = 0;
    int            done_cyc = 0;
    int            last_acc_cyc = 0;
    logic [DW-1:0] acc_a [0:63];
    logic [DW-1:0] acc_b [0:63];

    always @(posedge clkr) cyc <= cyc + 1;

    always @(negedge clkr) begin
        if (fiford && !empty) pop_n <= pop_n + 1;
        if (op_valid && op_ready && acc_n < 64) begin
            acc_a[acc_n] <= op_a;
            acc_b[acc_n] <= op_b;
            acc_n        <= acc_n + 1;
            last_acc_cyc <= cyc;
        end
        if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkr);
        #2;
    endtask

    task automatic load(input int v0, input int n);
        for (int i = 0; i < n; i++) mem[wr_cnt + i] = DW'(v0 + i);
        wr_cnt = wr_cnt + n;
    endtask

    // npairs is scrambled after the start edge; the DUT must use its latched copy.
    task automatic start_job(input int n);
        start  = 1'b1;
        npairs = CW'(n);
        tick();
        start  = 1'b0;
        npairs = 8'hAA;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (done_n > base) break;
            tick();
        end
        chk(tag, done_n - base, 1);
    endtask

    task automatic check_pairs(input int base, input int idx, input int n, input string tag);
        chk({tag, "_cnt"}, acc_n - base, n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_a"}, acc_a[base + i], mem[idx + 2 * i]);
            chk({tag, "_b"}, acc_b[base + i], mem[idx + 2 * i + 1]);
        end
    endtask

    int b_acc, b_pop, b_done, idx;

    initial begin
        repeat (3) tick();
        @(negedge clkr);
        chk("rst_fiford", fiford, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        tick();
        rst_n = 1'b0;
        tick();

        // 1: straight job, full throughput
        op_ready = 1'b1;
        idx = wr_cnt;
        load(1, 8);
        b_acc = acc_n; b_pop = pop_n; b_done = done_n;
        chk("t1_fiford_pre", fiford, 0);
        start_job(4);
        chk("t1_fiford_lat", fiford, 1);
        chk("t1_busy", busy, 1);
        wait_done(b_done, 100, "t1_done");
        check_pairs(b_acc, idx, 4, "t1");
        chk("t1_done_lat", done_cyc - last_acc_cyc, 1);
        repeat (3) tick();
        chk("t1_pops", pop_n - b_pop, 8);
        chk("t1_busy_end", busy, 0);

        // 2: consumer stalled, credit limit stops pops at 4
        op_ready = 1'b0;
        idx = wr_cnt;
        load(16'h100, 6);
        b_acc = acc_n; b_pop = pop_n; b_done = done_n;
        start_job(3);
        repeat (20) tick();
        chk("t2_pops_stall", pop_n - b_pop, 4);
        chk("t2_fiford_stall", fiford, 0);
        chk("t2_op_valid", op_valid, 1);
        chk("t2_op_a", op_a, 16'h100);
        chk("t2_op_b", op_b, 16'h101);
        chk("t2_busy", busy, 1);
        op_ready = 1'b1;
        wait_done(b_done, 100, "t2_done");
        check_pairs(b_acc, idx, 3, "t2");
        chk("t2_pops", pop_n - b_pop, 6);

        // 3: FIFO runs dry mid-job
        idx = wr_cnt;
        load(1, 3);
        b_acc = acc_n; b_pop = pop_n; b_done = done_n;
        start_job(3);
        repeat (10) tick();
        chk("t3_fiford_gap", fiford, 0);
        chk("t3_pops_gap", pop_n - b_pop, 3);
        chk("t3_pairs_gap", acc_n - b_acc, 1);
        chk("t3_busy_gap", busy, 1);
        load(4, 3);
        wait_done(b_done, 100, "t3_done");
        check_pairs(b_acc, idx, 3, "t3");

        // 4: zero-length job
        b_pop = pop_n;
        start  = 1'b1;
        npairs = '0;
        @(negedge clkr);
        chk("t4_done_early", done, 0);
        tick();
        start = 1'b0;
        @(negedge clkr);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_fiford", fiford, 0);
        tick();
        @(negedge clkr);
        chk("t4_done_pulse", done, 0);
        chk("t4_pops", pop_n - b_pop, 0);

        // 5: abort after the second pair, then a fresh one-pair job
        tick();
        idx = wr_cnt;
        load(16'h300, 12);
        b_acc = acc_n; b_done = done_n;
        start_job(5);
        for (int i = 0; i < 50; i++) begin
            if (acc_n - b_acc >= 2) break;
            tick();
        end
        chk("t5_pairs_before", acc_n - b_acc, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clkr);
        chk("t5_op_valid", op_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_fiford", fiford, 0);
        check_pairs(b_acc, idx, 2, "t5_pre");
        repeat (5) tick();
        chk("t5_no_done", done_n - b_done, 0);
        idx = rd_idx;
        b_acc = acc_n;
        start_job(1);
        wait_done(b_done, 50, "t5_done");
        check_pairs(b_acc, idx, 1, "t5_post");

        // 6: asynchronous reset with a RAM read in flight
        tick();
        load(16'h400, 8);
        start_job(3);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_fiford", fiford, 0);
        chk("t6_op_valid", op_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_op_a", op_a, 0);
        chk("t6_op_b", op_b, 0);
        tick();
        rst_n = 1'b0;
        tick();
        idx = rd_idx;
        b_acc = acc_n; b_done = done_n;
        start_job(2);
        wait_done(b_done, 100, "t6_done");
        check_pairs(b_acc, idx, 2, "t6");

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
